// File: rtl/seq_right_shifter_pkg.sv
// Shared ALU constants for the iterative right shifter.
// State encoding and shift-mode selectors.
package seq_right_shifter_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic SH_LOG = 1'b0;
    localparam logic SH_ARI = 1'b1;

endpackage

// File: rtl/seq_right_shifter_rshift_step.sv
// One-position right shift with an explicit fill bit.
// Purely combinational; the caller supplies the bit shifted in.
module rshift_step #(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] d,
    input  logic             fill,
    output logic [WIDTH-1:0] q
);

    // Shift the fill bit in at the MSB, dropping d[0]
    always_comb begin
        q = WIDTH'({fill, d} >> 1);
    end

endmodule

// File: rtl/seq_right_shifter.sv
// Iterative logical/arithmetic right shifter, one bit per clock.
// Handshake: ready in IDLE, start accepted there, valid pulse in DONE.
module seq_right_shifter
    import seq_right_shifter_pkg::*;
#(
    parameter int WIDTH = 6,
    parameter int AMT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             arith,
    input  logic [WIDTH-1:0] a,
    input  logic [AMT_W-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] C
);

    localparam logic [AMT_W-1:0] MAX_AMT = AMT_W'(WIDTH);
    localparam logic [AMT_W-1:0] ONE     = AMT_W'(1);

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [AMT_W-1:0] cnt;
    logic [AMT_W-1:0] amt_sat;
    logic             fill;
    logic             fill_new;
    logic [WIDTH-1:0] c_shift;

    rshift_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .d   (C),
        .fill(fill),
        .q   (c_shift)
    );

    // Clamp the amount so large requests saturate to all-fill
    always_comb begin
        amt_sat = (b >= MAX_AMT) ? MAX_AMT : b;
    end

    // Fill bit for a new operation: zero or operand sign
    always_comb begin
        fill_new = 1'b0;
        unique case (arith)
            SH_LOG:  fill_new = 1'b0;
            SH_ARI:  fill_new = a[WIDTH-1];
            default: fill_new = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:  state_next = start ? S_SHIFT : S_IDLE;
            S_SHIFT: state_next = (cnt == '0) ? S_DONE : S_SHIFT;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        ready = (state == S_IDLE);
        busy  = (state == S_SHIFT) || (state == S_DONE);
        valid = (state == S_DONE);
    end

    // Datapath: latch on accept, shift while count remains
    always_ff @(posedge clk) begin
        if (rst) begin
            C    <= '0;
            cnt  <= '0;
            fill <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        C    <= a;
                        cnt  <= amt_sat;
                        fill <= fill_new;
                    end
                end
                S_SHIFT: begin
                    if (cnt != '0) begin
                        C   <= c_shift;
                        cnt <= cnt - ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_right_shifter.sv
// Directed self-checking bench for seq_right_shifter.
// Cycle 0 is the cycle start is held high; checks sit 1ns after edges.
module tb_seq_right_shifter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       arith = 1'b0;
    logic [5:0] a = '0;
    logic [5:0] b = '0;
    logic       ready;
    logic       busy;
    logic       valid;
    logic [5:0] C;

    int n_checks = 0;
    int n_errors = 0;

    seq_right_shifter #(
        .WIDTH(6),
        .AMT_W(6)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .arith(arith),
        .a    (a),
        .b    (b),
        .ready(ready),
        .busy (busy),
        .valid(valid),
        .C    (C)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one op in the current (idle) cycle, wait for valid,
    // then step into the following idle cycle.
    task automatic run_op(input string tag, input logic [5:0] op_a,
                          input logic [5:0] op_b, input logic op_ar,
                          input logic [5:0] exp_c, input int exp_lat);
        int cyc;
        chk({tag, "_ready0"}, 32'(ready), 32'd1);
        a     = op_a;
        b     = op_b;
        arith = op_ar;
        start = 1'b1;
        step();
        start = 1'b0;
        a     = '0;
        b     = '0;
        arith = 1'b0;
        cyc   = 1;
        chk({tag, "_busy1"}, 32'(busy), 32'd1);
        while (!valid && cyc < 20) begin
            step();
            cyc++;
        end
        chk({tag, "_valid"}, 32'(valid), 32'd1);
        chk({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
        chk({tag, "_C"}, 32'(C), 32'(exp_c));
        step();
        chk({tag, "_ready_after"}, 32'(ready), 32'd1);
        chk({tag, "_valid_after"}, 32'(valid), 32'd0);
        chk({tag, "_C_hold"}, 32'(C), 32'(exp_c));
    endtask

    initial begin
        int cyc;
        int pulses;

        step();
        step();
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_C", 32'(C), 32'd0);
        rst = 1'b0;
        step();
        chk("idle_hold_C", 32'(C), 32'd0);

        run_op("log_b2", 6'b101100, 6'd2, 1'b0, 6'b001011, 4);
        run_op("ari_b2_neg", 6'b101100, 6'd2, 1'b1, 6'b111011, 4);
        run_op("ari_b2_pos", 6'b011100, 6'd2, 1'b1, 6'b000111, 4);
        run_op("b0", 6'b101100, 6'd0, 1'b0, 6'b101100, 2);
        run_op("log_b9", 6'b101100, 6'd9, 1'b0, 6'b000000, 8);
        run_op("ari_b9", 6'b101100, 6'd9, 1'b1, 6'b111111, 8);
        run_op("log_b63", 6'b101100, 6'd63, 1'b0, 6'b000000, 8);
        run_op("ari_b63", 6'b101100, 6'd63, 1'b1, 6'b111111, 8);
        run_op("log_b6", 6'b111111, 6'd6, 1'b0, 6'b000000, 8);
        run_op("log_b5", 6'b111111, 6'd5, 1'b0, 6'b000001, 7);

        // Start while busy must be ignored
        a     = 6'b111111;
        b     = 6'd3;
        arith = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        a     = 6'b000000;
        b     = 6'd1;
        arith = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_ign_ready", 32'(ready), 32'd0);
        cyc = 3;
        while (!valid && cyc < 20) begin
            step();
            cyc++;
        end
        chk("busy_ign_valid", 32'(valid), 32'd1);
        chk("busy_ign_lat", 32'(cyc), 32'd5);
        chk("busy_ign_C", 32'(C), 32'(6'b000111));
        step();
        run_op("b2b", 6'b100001, 6'd1, 1'b1, 6'b110000, 3);

        // Reset in the middle of an operation
        a     = 6'b110011;
        b     = 6'd5;
        arith = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        rst = 1'b1;
        start = 1'b1;
        step();
        rst = 1'b0;
        start = 1'b0;
        chk("midrst_ready", 32'(ready), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_valid", 32'(valid), 32'd0);
        chk("midrst_C", 32'(C), 32'd0);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (valid) pulses++;
        end
        chk("midrst_no_valid", 32'(pulses), 32'd0);
        run_op("post_rst", 6'b100000, 6'd5, 1'b1, 6'b111111, 7);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
